am9513_ctx_arbiter: RTL and testbench

AM9513_CTX_ARBITER -- requirements
Module: am9513_ctx_arbiter

---
 rtl/am9513_pkg.sv | 15 +
 rtl/am9513_age_counter.sv | 37 +++
 rtl/am9513_ctx_arbiter.sv | 134 +++++++++++++
 tb/tb_am9513_ctx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am9513_pkg.sv
// Shared types and constants for the AM9513 context-port arbiter.
// Requester indices identify the context-port masters.
package am9513_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StHandoff
   } arb_state_e;

   localparam int unsigned ReqCai    = 0;
   localparam int unsigned ReqLegacy = 1;
   localparam int unsigned ReqCsr    = 2;

endpackage

// File: rtl/am9513_age_counter.sv
// Saturating wait-age counter for one context-port requester.
// aged_o is set once the requester has waited AGE_LIMIT cycles.
module am9513_age_counter #(
   parameter int unsigned AGE_LIMIT = 16,
   parameter int unsigned CntW      = $clog2(AGE_LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic aged_o
);

   localparam logic [CntW-1:0] Limit = CntW'(AGE_LIMIT);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q < Limit)) begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign aged_o = (count_q >= Limit);

endmodule

// File: rtl/am9513_ctx_arbiter.sv
// Context-port ownership arbiter: fixed priority with age promotion, no preemption,
// a one-cycle all-low handoff gap between tenures, and sticky write-collision flags.
module am9513_ctx_arbiter
   import am9513_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = 3,
   parameter  int unsigned AGE_LIMIT = 16,
   localparam int unsigned IdxW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arb_en,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] we_attempt,
   input  logic               err_clr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               owner_valid,
   output logic [IdxW-1:0]    owner_idx,
   output logic               collision_err,
   output logic [NUM_REQ-1:0] err_src,
   output logic               promote_pulse
);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] src_q, src_d;
   logic [NUM_REQ-1:0] aged, win_oh, bad_we;
   logic [IdxW-1:0]    fp_idx, age_idx, win_idx;
   logic               fp_found, any_aged;
   logic               promote_q, promote_d;
   logic               err_q, err_d;
   logic               rdy_q;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
      am9513_age_counter #(
         .AGE_LIMIT(AGE_LIMIT)
      ) u_age (
         .clk   (clk),
         .rst_n (rst_n),
         .inc_i (req[g] & ~gnt_q[g]),
         .clr_i (~req[g] | gnt_d[g]),
         .aged_o(aged[g])
      );
   end

   // Lowest-index requester overall, and lowest-index requester that has aged out.
   always_comb begin
      fp_idx   = '0;
      age_idx  = '0;
      fp_found = 1'b0;
      any_aged = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !fp_found) begin
            fp_idx   = IdxW'(i);
            fp_found = 1'b1;
         end
         if (req[i] && aged[i] && !any_aged) begin
            age_idx  = IdxW'(i);
            any_aged = 1'b1;
         end
      end
      win_idx = any_aged ? age_idx : fp_idx;
      win_oh  = NUM_REQ'(1) << win_idx;
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      promote_d = 1'b0;
      case (state_q)
         StGrant: begin
            if (!(|(req & gnt_q))) begin
               gnt_d   = '0;
               state_d = StHandoff;
            end
         end
         StIdle, StHandoff: begin
            gnt_d   = '0;
            state_d = StIdle;
            // rdy_q holds off arbitration for the first edge after reset.
            if (rdy_q && arb_en && (|req)) begin
               gnt_d     = win_oh;
               state_d   = StGrant;
               promote_d = any_aged && (age_idx != fp_idx);
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // A set in the same cycle as err_clr wins.
   always_comb begin
      bad_we = we_attempt & ~gnt_q;
      src_d  = (err_clr ? '0 : src_q) | bad_we;
      err_d  = (err_clr ? 1'b0 : err_q) | (|bad_we);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         gnt_q     <= '0;
         promote_q <= 1'b0;
         src_q     <= '0;
         err_q     <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         promote_q <= promote_d;
         src_q     <= src_d;
         err_q     <= err_d;
         rdy_q     <= 1'b1;
      end
   end

   always_comb begin
      owner_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            owner_idx = IdxW'(i);
         end
      end
   end

   assign gnt           = gnt_q;
   assign owner_valid   = |gnt_q;
   assign promote_pulse = promote_q;
   assign collision_err = err_q;
   assign err_src       = src_q;

endmodule

// File: tb/tb_am9513_ctx_arbiter.sv
// Self-checking bench for am9513_ctx_arbiter: directed scenarios plus a randomized
// run compared against an owner/wait-time reference model.
module tb_am9513_ctx_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AL = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         arb_en = 1'b1;
   logic         err_clr = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] we = '0;
   logic [N-1:0] gnt, err_src;
   logic [1:0]   owner_idx;
   logic         owner_valid, collision_err, promote_pulse;

   int checks = 0;
   int failures = 0;

   // Reference model: who owns the port, how long each requester has waited.
   int           m_owner;
   bit           m_ready;
   int           m_wait[N];
   bit           m_promote;
   logic [N-1:0] m_src;

   always #5 clk = ~clk;

   am9513_ctx_arbiter #(
      .NUM_REQ  (N),
      .AGE_LIMIT(AL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arb_en       (arb_en),
      .req          (req),
      .we_attempt   (we),
      .err_clr      (err_clr),
      .gnt          (gnt),
      .owner_valid  (owner_valid),
      .owner_idx    (owner_idx),
      .collision_err(collision_err),
      .err_src      (err_src),
      .promote_pulse(promote_pulse)
   );

   function automatic logic [N-1:0] m_gnt();
      return (m_owner < 0) ? '0 : N'(1 << m_owner);
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_ready   = 1'b0;
      m_promote = 1'b0;
      m_src     = '0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
   endtask

   // Advance one clock: predict from pre-edge inputs, then sample 1 ns after the edge.
   task automatic tick();
      int           nxt_owner, first_req, first_aged;
      bit           nxt_promote;
      int           nxt_wait[N];
      logic [N-1:0] cur_gnt, nxt_src;
      cur_gnt     = m_gnt();
      nxt_owner   = m_owner;
      nxt_promote = 1'b0;
      first_req   = -1;
      first_aged  = -1;
      if (m_owner >= 0) begin
         if (!req[m_owner]) nxt_owner = -1;
      end else if (m_ready && arb_en && (req != '0)) begin
         for (int i = 0; i < N; i++) begin
            if (req[i] && first_req < 0) first_req = i;
            if (req[i] && m_wait[i] >= int'(AL) && first_aged < 0) first_aged = i;
         end
         nxt_owner   = (first_aged >= 0) ? first_aged : first_req;
         nxt_promote = (first_aged >= 0) && (first_aged != first_req);
      end
      for (int i = 0; i < N; i++) begin
         if (!req[i] || nxt_owner == i) nxt_wait[i] = 0;
         else if (cur_gnt[i]) nxt_wait[i] = m_wait[i];
         else nxt_wait[i] = (m_wait[i] + 1 > int'(AL)) ? int'(AL) : m_wait[i] + 1;
      end
      nxt_src = (err_clr ? '0 : m_src) | (we & ~cur_gnt);
      @(posedge clk);
      #1;
      m_owner   = nxt_owner;
      m_promote = nxt_promote;
      m_src     = nxt_src;
      m_ready   = 1'b1;
      for (int i = 0; i < N; i++) m_wait[i] = nxt_wait[i];
   endtask

   task automatic idle_all();
      req = '0; we = '0; arb_en = 1'b1; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({gnt, owner_valid, owner_idx, collision_err, err_src, promote_pulse} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: gnt=%b ov=%b idx=%0d err=%b src=%b pr=%b want all 0",
                  gnt, owner_valid, owner_idx, collision_err, err_src, promote_pulse);
      end
      rst_n = 1'b1;
      req = 3'b010;
      tick();
      checks++;
      if (gnt !== 3'b000) begin
         failures++; $display("FAIL reset_first_edge: gnt=%b want 000", gnt);
      end
      tick();
      checks++;
      if (gnt !== 3'b010) begin
         failures++; $display("FAIL reset_second_edge: gnt=%b want 010", gnt);
      end
      idle_all();
   endtask

   task automatic test_handoff();
      req = 3'b110;
      tick();
      checks++;
      if (gnt !== 3'b010 || owner_idx !== 2'd1 || owner_valid !== 1'b1) begin
         failures++;
         $display("FAIL handoff_grant: gnt=%b idx=%0d ov=%b want 010/1/1", gnt, owner_idx,
                  owner_valid);
      end
      req = 3'b100;
      tick();
      checks++;
      if (gnt !== 3'b000 || owner_valid !== 1'b0 || owner_idx !== 2'd0) begin
         failures++;
         $display("FAIL handoff_gap: gnt=%b ov=%b idx=%0d want 000/0/0", gnt, owner_valid,
                  owner_idx);
      end
      tick();
      checks++;
      if (gnt !== 3'b100 || owner_idx !== 2'd2) begin
         failures++; $display("FAIL handoff_next: gnt=%b idx=%0d want 100/2", gnt, owner_idx);
      end
      idle_all();
   endtask

   task automatic test_aging();
      req = 3'b111;
      tick();
      checks++;
      if (gnt !== 3'b001 || promote_pulse !== 1'b0) begin
         failures++; $display("FAIL aging_first: gnt=%b pr=%b want 001/0", gnt, promote_pulse);
      end
      // LEGACY drops briefly so only CSR has aged when CAI lets go.
      for (int i = 0; i < 20; i++) begin
         req = (i == 15) ? 3'b101 : 3'b111;
         tick();
      end
      req = 3'b110;
      tick();
      checks++;
      if (gnt !== 3'b000) begin
         failures++; $display("FAIL aging_gap: gnt=%b want 000", gnt);
      end
      tick();
      checks++;
      if (gnt !== 3'b100 || promote_pulse !== 1'b1) begin
         failures++; $display("FAIL aging_promote: gnt=%b pr=%b want 100/1", gnt, promote_pulse);
      end
      tick();
      checks++;
      if (gnt !== 3'b100 || promote_pulse !== 1'b0) begin
         failures++; $display("FAIL aging_pulse_len: gnt=%b pr=%b want 100/0", gnt, promote_pulse);
      end
      idle_all();
   endtask

   task automatic test_collision();
      req = 3'b001;
      tick();
      we = 3'b100;
      tick();
      checks++;
      if (collision_err !== 1'b1 || err_src !== 3'b100 || gnt !== 3'b001) begin
         failures++;
         $display("FAIL collision_set: err=%b src=%b gnt=%b want 1/100/001", collision_err,
                  err_src, gnt);
      end
      we = 3'b010; err_clr = 1'b1;
      tick();
      checks++;
      if (collision_err !== 1'b1 || err_src !== 3'b010) begin
         failures++;
         $display("FAIL collision_set_wins: err=%b src=%b want 1/010", collision_err, err_src);
      end
      we = 3'b000;
      tick();
      checks++;
      if (collision_err !== 1'b0 || err_src !== 3'b000) begin
         failures++; $display("FAIL collision_clear: err=%b src=%b want 0/000", collision_err,
                              err_src);
      end
      we = 3'b001; err_clr = 1'b0;
      tick();
      checks++;
      if (collision_err !== 1'b0 || gnt !== 3'b001) begin
         failures++; $display("FAIL collision_owner_write: err=%b gnt=%b want 0/001",
                              collision_err, gnt);
      end
      idle_all();
   endtask

   task automatic test_arb_en();
      arb_en = 1'b0; req = 3'b010;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (gnt !== 3'b000) begin
            failures++; $display("FAIL arb_en_low_%0d: gnt=%b want 000", i, gnt);
         end
      end
      arb_en = 1'b1;
      tick();
      checks++;
      if (gnt !== 3'b010) begin
         failures++; $display("FAIL arb_en_rise: gnt=%b want 010", gnt);
      end
      arb_en = 1'b0;
      repeat (3) tick();
      checks++;
      if (gnt !== 3'b010) begin
         failures++; $display("FAIL arb_en_tenure: gnt=%b want 010", gnt);
      end
      req = 3'b000;
      tick();
      req = 3'b010;
      repeat (4) tick();
      checks++;
      if (gnt !== 3'b000) begin
         failures++; $display("FAIL arb_en_after_release: gnt=%b want 000", gnt);
      end
      arb_en = 1'b1;
      tick();
      checks++;
      if (gnt !== 3'b010) begin
         failures++; $display("FAIL arb_en_regrant: gnt=%b want 010", gnt);
      end
      idle_all();
   endtask

   task automatic test_async_reset();
      req = 3'b001;
      tick();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (gnt !== 3'b000 || owner_valid !== 1'b0) begin
         failures++; $display("FAIL async_reset: gnt=%b ov=%b want 000/0", gnt, owner_valid);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (gnt !== 3'b000) begin
         failures++; $display("FAIL async_release_edge1: gnt=%b want 000", gnt);
      end
      tick();
      checks++;
      if (gnt !== 3'b001) begin
         failures++; $display("FAIL async_release_edge2: gnt=%b want 001", gnt);
      end
      idle_all();
   endtask

   task automatic test_random();
      logic [N-1:0] prev_gnt;
      prev_gnt = gnt;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (i == m_owner) req[i] = ($urandom_range(0, 7) != 0);
            else if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            we[i] = ($urandom_range(0, 7) == 0);
         end
         err_clr = ($urandom_range(0, 15) == 0);
         arb_en  = ($urandom_range(0, 15) != 0);
         tick();
         checks++;
         if ({gnt, promote_pulse, collision_err, err_src} !==
             {m_gnt(), m_promote, (m_src != '0), m_src}) begin
            failures++;
            $display("FAIL random_c%0d: gnt=%b pr=%b err=%b src=%b want %b/%b/%b/%b", c, gnt,
                     promote_pulse, collision_err, err_src, m_gnt(), m_promote, (m_src != '0),
                     m_src);
         end
         checks++;
         if (!$onehot0(gnt) || (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt) ||
             owner_valid !== (m_owner >= 0) ||
             owner_idx !== ((m_owner >= 0) ? 2'(m_owner) : 2'd0)) begin
            failures++;
            $display("FAIL random_inv_c%0d: gnt=%b prev=%b ov=%b idx=%0d want owner %0d", c,
                     gnt, prev_gnt, owner_valid, owner_idx, m_owner);
         end
         prev_gnt = gnt;
      end
      idle_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_handoff();
      test_aging();
      test_collision();
      test_arb_en();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
